// File: rtl/mag_pkg.sv
// Shared types and default widths for the magnitude arbiter slice.
package mag_pkg;

    localparam int unsigned DEF_NREQ = 2;
    localparam int unsigned DEF_DW   = 8;

    // Widths derived from the default configuration.
    localparam int unsigned SUM_W  = 2 * DEF_DW + 1;
    localparam int unsigned ROOT_W = DEF_DW + 1;
    localparam int unsigned ID_W   = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSquare,
        StRoot,
        StResp
    } mag_state_e;

endpackage

// File: rtl/mag_isqrt_seq.sv
// Restoring bit-serial integer square root, one result bit per enabled cycle, MSB first.
// Optional build macro MAG_ROUND_EN: round the final result to nearest instead of floor.
module mag_isqrt_seq
    import mag_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic [2*DW:0] sum,
    output logic          done,
    output logic [DW:0]   root
);

    localparam int unsigned SumW  = 2 * DW + 1;
    localparam int unsigned RootW = DW + 1;
    localparam int unsigned SqW   = 2 * RootW;
    localparam int unsigned KW    = $clog2(RootW);

    logic             active_q, active_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SumW-1:0]  sum_q, sum_d;
    logic [RootW-1:0] root_q, root_d;

    logic [RootW-1:0] trial;
    logic [SqW-1:0]   trial_sq;
    logic [RootW-1:0] root_step;
    logic [RootW-1:0] root_fin;
`ifdef MAG_ROUND_EN
    logic [SqW-1:0]   rem;
`endif

    // Trial compare for the current bit; root_fin is only consumed on the last step.
    always_comb begin
        trial     = root_q | (RootW'(1) << k_q);
        trial_sq  = SqW'(trial) * SqW'(trial);
        root_step = (trial_sq <= SqW'(sum_q)) ? trial : root_q;
`ifdef MAG_ROUND_EN
        // root_step^2 <= sum always holds, so the remainder cannot underflow.
        rem      = SqW'(sum_q) - SqW'(root_step) * SqW'(root_step);
        root_fin = (rem > SqW'(root_step)) ? root_step + RootW'(1) : root_step;
`else
        root_fin = root_step;
`endif
    end

    assign done = active_q && (k_q == '0);
    assign root = root_fin;

    // Next-state: load on start, then walk k from DW down to 0.
    always_comb begin
        active_d = active_q;
        k_d      = k_q;
        sum_d    = sum_q;
        root_d   = root_q;
        if (ena) begin
            if (start) begin
                active_d = 1'b1;
                k_d      = KW'(DW);
                sum_d    = sum;
                root_d   = '0;
            end else if (active_q) begin
                root_d = root_step;
                if (k_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            k_q      <= '0;
            sum_q    <= '0;
            root_q   <= '0;
        end else begin
            active_q <= active_d;
            k_q      <= k_d;
            sum_q    <= sum_d;
            root_q   <= root_d;
        end
    end

endmodule

// File: rtl/mag_arbiter_ctrl.sv
// Round-robin front end sharing one iterative sqrt(x^2 + y^2) unit between NREQ requesters.
// Optional build macro MAG_ROUND_EN (passed to mag_isqrt_seq): round-to-nearest result.
module mag_arbiter_ctrl
    import mag_pkg::*;
#(
    parameter int unsigned  NREQ = DEF_NREQ,
    parameter int unsigned  DW   = DEF_DW,
    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_x,
    input  logic [NREQ*DW-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW:0]        rsp_mag,
    output logic [IdW-1:0]     rsp_id,
    output logic               busy
);

    localparam int unsigned SumW  = 2 * DW + 1;
    localparam int unsigned RootW = DW + 1;

    mag_state_e       state_q, state_d;
    logic [IdW-1:0]   rr_last_q, rr_last_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [DW-1:0]    x_q, x_d, y_q, y_d;
    logic [RootW-1:0] mag_q, mag_d;

    logic [NREQ-1:0]  grant;
    logic             gnt_found;
    logic [IdW-1:0]   gnt_id;
    logic [DW-1:0]    sel_x, sel_y;
    int unsigned      idx;
    logic [SumW-1:0]  sq_sum;
    logic             root_start;
    logic             root_done;
    logic [RootW-1:0] root_val;

    // Rotating priority search starting just above the last served requester.
    always_comb begin
        grant     = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = 32'(rr_last_q) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[IdW'(idx)]) begin
                gnt_found           = 1'b1;
                gnt_id              = IdW'(idx);
                grant[IdW'(idx)]    = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*DW +: DW];
                sel_y = req_y[i*DW +: DW];
            end
        end
    end

    assign req_ready  = (state_q == StIdle && ena) ? grant : '0;
    assign sq_sum     = SumW'(x_q) * SumW'(x_q) + SumW'(y_q) * SumW'(y_q);
    assign root_start = (state_q == StSquare);

    mag_isqrt_seq #(
        .DW (DW)
    ) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (root_start),
        .sum   (sq_sum),
        .done  (root_done),
        .root  (root_val)
    );

    // FSM next-state and job register updates; nothing advances while ena is low.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        x_d       = x_q;
        y_d       = y_q;
        mag_d     = mag_q;
        if (ena) begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        state_d   = StSquare;
                        x_d       = sel_x;
                        y_d       = sel_y;
                        id_d      = gnt_id;
                        rr_last_d = gnt_id;
                    end
                end
                StSquare: state_d = StRoot;
                StRoot: begin
                    if (root_done) begin
                        state_d = StResp;
                        mag_d   = root_val;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_last_q <= IdW'(NREQ - 1);
            id_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            mag_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            x_q       <= x_d;
            y_q       <= y_d;
            mag_q     <= mag_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_mag   = mag_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != StIdle);

endmodule
